lsu_byte_seq: RTL and testbench
===============================

Name: lsu_byte_seq

Overview:
- Load/store sequencer on the CPU side of the byte-wide data memory; it is the initiator of the memory access protocol.
- Accepts one load/store request (word, halfword or byte, signed or unsigned) from the pipeline.
- Splits the request into single-byte memory accesses, little-endian, one per cycle.
- For loads, reassembles and zero/sign-extends the returned bytes into a 32-bit response.

Parameters:
ADDR_W, 6, byte-address width of the data memory (64 bytes).

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  block idle, can accept a request
req_we  input  1  1 = store, 0 = load
req_type  input  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned
req_addr  input  ADDR_W  byte address of the lowest byte
req_wdata  input  32  store data
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load result
resp_err  output  1  misalignment error, qualified by resp_valid
mem_en  output  1  byte access strobe
mem_we  output  1  byte write enable
mem_addr  output  ADDR_W  byte address
mem_wdata  output  8  write byte
mem_rdata  input  8  read byte, valid the cycle after its mem_en/mem_addr (synchronous RAM)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state IDLE; counter 0; resp_valid 0; resp_rdata 0; resp_err 0; mem_en 0; mem_we 0; mem_addr 0; mem_wdata 0.
- req_ready is 1 exactly when state is IDLE. It is therefore 1 during reset.
- Byte count N: 4 for type 000; 2 for 001/010; 1 for 011/100. Store uses only the width; signedness is ignored.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: on req_valid && req_ready at edge T, latch we/type/addr/wdata and clear counter k.
  - Valid types go to ACCESS.
  - Types 101–111 go straight to DONE with no memory access; resp_rdata is set to 0.
- ACCESS, cycle k = 0..N-1:
  - mem_en = 1, mem_addr = addr + k (mod 2^ADDR_W, wraps silently), mem_we = we.
  - mem_wdata = wdata[8k+7:8k].
  - For loads, the byte returned for access k-1 is captured into assembly byte k-1.
  - After k = N-1: stores go to DONE; loads go to WAIT.
- WAIT (loads only): mem_en = 0; capture byte N-1; go to DONE.
- DONE: resp_valid = 1 for exactly one cycle, then IDLE.
  - For loads, resp_rdata is updated on entry to DONE:
    - sign extension from bit 8N-1 for types 000/001/011;
    - zero extension for types 010/100.
  - For stores, resp_rdata holds its previous value.
- mem_en, mem_we, mem_addr and mem_wdata are 0 in IDLE, WAIT and DONE.
- Latency, request accepted at edge T:
  - Store: byte accesses in cycles T+1..T+N; resp_valid in cycle T+N+1.
  - Load: accesses in T+1..T+N; WAIT in T+N+1; resp_valid in T+N+2.
- No pipelining: the next request can be accepted at the earliest in the cycle after DONE.
- req_* inputs are ignored outside IDLE; only the latched copies are used.
- Reset mid-operation: the access is abandoned and mem_en/mem_we drop immediately (asynchronously). No resp_valid is produced. Bytes already stored stay written.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - Word with addr[1:0] != 0, or half with addr[0] != 0, goes IDLE -> DONE with no memory access.
  - resp_err = 1 with resp_valid; resp_rdata unchanged.
  - resp_err = 0 on all other responses.
- Undefined:
  - resp_err is tied to 0.
  - Misaligned accesses proceed byte by byte at addr..addr+N-1 with address wrap.

Test Plan:
- Store word 0x8765_4321 to addr 4 -> mem writes 0x21@4, 0x43@5, 0x65@6, 0x87@7 in cycles T+1..T+4; resp_valid at T+5.
- Load word from addr 4 -> resp_rdata 0x8765_4321 at T+6; req_ready low T+1..T+6.
- Load with memory byte 0xF0 at addr 9: type 011 -> 0xFFFF_FFF0; type 100 -> 0x0000_00F0. Halfword 0x80F0 at 8/9: type 001 -> 0xFFFF_80F0; type 010 -> 0x0000_80F0.
- Store half 0xBEEF at addr 63 (macro off) -> 0xEF@63, 0xBE@0 (wrap). Macro on -> resp_err = 1, no mem_en pulse.
- req_type 111 load -> resp_valid at T+1 with resp_rdata 0 and no memory access.
- Word store, rstn dropped at T+2 -> mem_en 0 immediately; only the byte at addr is written. After release: req_ready = 1, no resp_valid.

Source files
------------

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer: splits word/half/byte requests into little-endian
// single-byte RAM accesses and sign/zero-extends load data. Option: LSU_ALIGN_CHECK_EN.
module lsu_byte_seq #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [2:0]          r_type;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [1:0]          r_cnt;
  logic [31:0]         r_asm;
  logic [31:0]         r_rdata;
  logic                w_accept;
  logic                w_type_ok;
  logic                w_misalign;
  logic [1:0]          w_nlast;
  logic                w_last;
  logic [31:0]         w_full;
  logic [31:0]         w_ext;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign resp_rdata = r_rdata;
  assign w_accept   = req_valid && req_ready;
  assign w_type_ok  = (req_type <= 3'b100);

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = ((req_type == 3'b000) && (req_addr[1:0] != 2'b00)) ||
                      (((req_type == 3'b001) || (req_type == 3'b010)) && req_addr[0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Index of the last byte of the latched request (N-1)
  always_comb begin
    w_nlast = 2'd0;
    case (r_type)
      3'b000:          w_nlast = 2'd3;
      3'b001, 3'b010:  w_nlast = 2'd1;
      default:         w_nlast = 2'd0;
    endcase
  end

  assign w_last = (r_cnt == w_nlast);

  // The final byte is still on mem_rdata during WAIT, so splice it in combinationally
  always_comb begin
    w_full = r_asm;
    w_full[{w_nlast, 3'b000} +: 8] = mem_rdata;
  end

  always_comb begin
    w_ext = w_full;
    case (r_type)
      3'b001:  w_ext = {{16{w_full[15]}}, w_full[15:0]};
      3'b010:  w_ext = {16'h0000, w_full[15:0]};
      3'b011:  w_ext = {{24{w_full[7]}}, w_full[7:0]};
      3'b100:  w_ext = {24'h000000, w_full[7:0]};
      default: w_ext = w_full;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Memory strobes decode from state so reset removes them without waiting for a clock
  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_type_ok || w_misalign) w_next = S_DONE;
          else                          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr + ADDR_W'(r_cnt);
        mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
        if (w_last) w_next = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we    <= 1'b0;
      r_type  <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_cnt   <= 2'd0;
      r_asm   <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_type  <= req_type;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= 2'd0;
            if (!w_type_ok) r_rdata <= 32'h0;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 2'd1;
          if (!r_we && (r_cnt != 2'd0)) r_asm[{r_cnt - 2'd1, 3'b000} +: 8] <= mem_rdata;
        end
        S_WAIT:  r_rdata <= w_ext;
        default: ;
      endcase
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_err <= 1'b0;
    else if (w_accept) r_err <= w_misalign;
  end

  assign resp_err = r_err;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed bench for lsu_byte_seq: issue tasks queue expected accesses and responses,
// a negedge monitor compares them against a 64-byte synchronous RAM model.
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'b000;
  logic [5:0]  req_addr = 6'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] tmem [64];

  typedef struct {int cyc; logic [31:0] rdata; logic err;} resp_t;
  typedef struct {int cyc; logic [5:0] addr; logic we; logic [7:0] data;} acc_t;
  resp_t resp_q[$];
  acc_t  acc_q[$];

  lsu_byte_seq #(.ADDR_W(6)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= tmem[mem_addr];
      if (mem_we) tmem[mem_addr] = mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_en) begin
      if (acc_q.size() == 0) begin
        chk("unexpected_mem_en", {26'h0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        acc_t a;
        a = acc_q.pop_front();
        chk("acc_cycle", cyc, a.cyc);
        chk("acc_addr", {26'h0, mem_addr}, {26'h0, a.addr});
        chk("acc_we", {31'h0, mem_we}, {31'h0, a.we});
        if (a.we) chk("acc_wdata", {24'h0, mem_wdata}, {24'h0, a.data});
        chk("ready_busy", {31'h0, req_ready}, 32'h0);
      end
    end
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("resp_cycle", cyc, r.cyc);
        chk("resp_rdata", resp_rdata, r.rdata);
        chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
        chk("ready_done", {31'h0, req_ready}, 32'h0);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] typ, input logic [5:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int n_acc, input bit push_resp);
    int guard;
    int acc;
    logic [31:0] wtmp;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("ready_timeout", 32'h0, 32'h1);
    acc = cyc + 1;
    wtmp = wd;
    for (int k = 0; k < n_acc; k++)
      acc_q.push_back('{acc + k, addr + 6'(k), we, wtmp[8*k +: 8]});
    if (push_resp)
      resp_q.push_back('{(n_acc == 0) ? acc : (we ? acc + n_acc : acc + n_acc + 1), exp_rd, exp_err});
    req_we = we; req_type = typ; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((resp_q.size() != 0 || acc_q.size() != 0) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", resp_q.size() + acc_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tmem[i] = 8'h00;
    #3;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {26'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    issue(1'b1, 3'b000, 6'd4, 32'h8765_4321, 32'h0, 1'b0, 4, 1'b1);
    wait_done();
    issue(1'b0, 3'b000, 6'd4, 32'h0, 32'h8765_4321, 1'b0, 4, 1'b1);
    wait_done();

    tmem[9] = 8'hF0;
    issue(1'b0, 3'b011, 6'd9, 32'h0, 32'hFFFF_FFF0, 1'b0, 1, 1'b1);
    wait_done();
    issue(1'b0, 3'b100, 6'd9, 32'h0, 32'h0000_00F0, 1'b0, 1, 1'b1);
    wait_done();

    tmem[8] = 8'hF0; tmem[9] = 8'h80;
    issue(1'b0, 3'b001, 6'd8, 32'h0, 32'hFFFF_80F0, 1'b0, 2, 1'b1);
    wait_done();
    issue(1'b0, 3'b010, 6'd8, 32'h0, 32'h0000_80F0, 1'b0, 2, 1'b1);
    wait_done();

`ifdef LSU_ALIGN_CHECK_EN
    issue(1'b1, 3'b001, 6'd63, 32'h0000_BEEF, 32'h0000_80F0, 1'b1, 0, 1'b1);
    wait_done();
    issue(1'b0, 3'b000, 6'd63, 32'h0, 32'h0000_80F0, 1'b1, 0, 1'b1);
    wait_done();
    chk("align_no_write63", {24'h0, tmem[63]}, 32'h0);
`else
    issue(1'b1, 3'b001, 6'd63, 32'h0000_BEEF, 32'h0000_80F0, 1'b0, 2, 1'b1);
    wait_done();
    chk("wrap_mem63", {24'h0, tmem[63]}, 32'hEF);
    chk("wrap_mem0", {24'h0, tmem[0]}, 32'hBE);
    issue(1'b0, 3'b000, 6'd63, 32'h0, 32'h0000_BEEF, 1'b0, 4, 1'b1);
    wait_done();
`endif

    issue(1'b0, 3'b111, 6'd0, 32'h0, 32'h0, 1'b0, 0, 1'b1);
    wait_done();

    issue(1'b1, 3'b011, 6'd30, 32'h1234_565A, 32'h0, 1'b0, 1, 1'b1);
    wait_done();
    issue(1'b0, 3'b100, 6'd30, 32'h0, 32'h0000_005A, 1'b0, 1, 1'b1);
    wait_done();

    // Abort a word store after its first byte has been written
    issue(1'b1, 3'b000, 6'd20, 32'hAABB_CCDD, 32'h0, 1'b0, 1, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("abort_mem_en", {31'h0, mem_en}, 32'h0);
    chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_mem20", {24'h0, tmem[20]}, 32'hDD);
    chk("abort_mem21", {24'h0, tmem[21]}, 32'h00);
    chk("abort_rdata", resp_rdata, 32'h0);
    repeat (6) @(negedge clk);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
